// File: rtl/jk_ctrl_pkg.sv
// Shared JK latch-bank control encodings.
// Command and sequencer state encodings plus the expected-Q helper.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    localparam int CELLS = 4;

    // Value a JK cell should show after one strobe of cmd from prev.
    function automatic logic exp_q(input cmd_e cmd, input logic prev);
        logic r;
        r = prev;
        unique case (cmd)
            CMD_HOLD:   r = prev;
            CMD_RESET:  r = 1'b0;
            CMD_SET:    r = 1'b1;
            CMD_TOGGLE: r = ~prev;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, A favoured out of reset.
// The last-served requester loses a tie on the next arbitration.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic prio_b_q;

    // One-hot grant: uncontested requests win, ties go to the favoured side.
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~prio_b_q | ~req[1]);
        gnt[1] = req[1] & (prio_b_q | ~req[0]);
    end

    // Favour the other side once a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else if (advance && (|gnt)) begin
            prio_b_q <= gnt[0];
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrates two requesters onto a 4-cell external JK latch bank.
// Define JK_BANK_VERIFY_EN to add the sticky err readback checker.
module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    input  logic [1:0] sel_a,
    input  logic [1:0] sel_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [3:0] J,
    output logic [3:0] K,
    output logic [3:0] En,
    input  logic [3:0] Q,
    output logic       rd_q,
    output logic       busy
`ifdef JK_BANK_VERIFY_EN
    ,
    output logic       err
`endif
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cmd_e       cmd_q;
    logic [1:0] sel_q;
    logic       own_b_q;
    logic [1:0] arb_gnt;
    logic       idle;
    logic       take;
    logic [1:0] win_sel;

    assign idle    = (state_q == ST_IDLE);
    assign take    = idle & rst_n & (|arb_gnt);
    assign gnt_a   = take & arb_gnt[0];
    assign gnt_b   = take & arb_gnt[1];
    assign busy    = ~idle;
    assign win_sel = arb_gnt[1] ? sel_b : sel_a;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req_b, req_a}),
        .advance (take),
        .gnt     (arb_gnt)
    );

    // Sequencer next state and per-cell drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        J       = '0;
        K       = '0;
        En      = '0;
        done_a  = 1'b0;
        done_b  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                J[sel_q] = cmd_q[1];
                K[sel_q] = cmd_q[0];
                if (cnt_q == 4'(SETUP_CYC - 1)) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STROBE: begin
                J[sel_q]  = cmd_q[1];
                K[sel_q]  = cmd_q[0];
                En[sel_q] = 1'b1;
                if (cnt_q == 4'(STROBE_CYC - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                J[sel_q] = cmd_q[1];
                K[sel_q] = cmd_q[0];
                done_a   = ~own_b_q;
                done_b   = own_b_q;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State, phase counter and readback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_HOLD) begin
                rd_q <= Q[sel_q];
            end
        end
    end

    // Latch the winner's command when its grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= CMD_HOLD;
            sel_q   <= '0;
            own_b_q <= 1'b0;
        end else if (take) begin
            cmd_q   <= arb_gnt[1] ? cmd_e'(cmd_b) : cmd_e'(cmd_a);
            sel_q   <= win_sel;
            own_b_q <= arb_gnt[1];
        end
    end

`ifdef JK_BANK_VERIFY_EN
    logic prev_q;

    // Snapshot the cell before the strobe, flag a wrong result at HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (take) begin
                prev_q <= Q[win_sel];
            end
            if ((state_q == ST_HOLD) &&
                (Q[sel_q] != exp_q(cmd_q, prev_q))) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural JK latch bank.
// Build with JK_BANK_VERIFY_EN to also cover the err checker.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [1:0] cmd_a, cmd_b, sel_a, sel_b;
    logic       gnt_a, gnt_b, done_a, done_b;
    logic [3:0] J, K, En;
    logic [3:0] Q = 4'b0000;
    logic       rd_q, busy;
    logic       force0 = 1'b0;
`ifdef JK_BANK_VERIFY_EN
    logic       err;
`endif

    logic       req1;
    logic       g1a, g1b, d1a, d1b, rd1, busy1;
    logic [3:0] j1, k1, en1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (req_a),
        .req_b  (req_b),
        .cmd_a  (cmd_a),
        .cmd_b  (cmd_b),
        .sel_a  (sel_a),
        .sel_b  (sel_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .done_a (done_a),
        .done_b (done_b),
        .J      (J),
        .K      (K),
        .En     (En),
        .Q      (Q),
        .rd_q   (rd_q),
        .busy   (busy)
`ifdef JK_BANK_VERIFY_EN
        ,
        .err    (err)
`endif
    );

    jk_bank_arbiter #(
        .SETUP_CYC  (3),
        .STROBE_CYC (2)
    ) dut_slow (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (req1),
        .req_b  (1'b0),
        .cmd_a  (2'b10),
        .cmd_b  (2'b00),
        .sel_a  (2'd0),
        .sel_b  (2'd0),
        .gnt_a  (g1a),
        .gnt_b  (g1b),
        .done_a (d1a),
        .done_b (d1b),
        .J      (j1),
        .K      (k1),
        .En     (en1),
        .Q      (4'b0000),
        .rd_q   (rd1),
        .busy   (busy1)
`ifdef JK_BANK_VERIFY_EN
        ,
        .err    ()
`endif
    );

    // Latch bank model: a strobed cell takes its JK action at the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (En[i]) begin
                case ({J[i], K[i]})
                    2'b01:   Q[i] <= 1'b0;
                    2'b10:   Q[i] <= 1'b1;
                    2'b11:   Q[i] <= ~Q[i];
                    default: Q[i] <= Q[i];
                endcase
            end
        end
        if (force0) Q[0] <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int en_cnt;
        int done_at;
        rst_n = 1'b0;
        req_a = 0; req_b = 0; req1 = 0;
        cmd_a = 2'b00; cmd_b = 2'b00;
        sel_a = 2'd0; sel_b = 2'd0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_en", En, 0);
        chk("rst_jk", {J, K}, 0);
        chk("rst_rdq", rd_q, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Set cell 2 with default timing.
        req_a = 1; cmd_a = 2'b10; sel_a = 2'd2;
        #1;
        chk("t1_gnt_a", gnt_a, 1);
        chk("t1_busy_idle", busy, 0);
        tick();
        req_a = 0;
        chk("t1_setup_en", En, 4'b0000);
        chk("t1_setup_j", J, 4'b0100);
        chk("t1_setup_k", K, 4'b0000);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_strobe_en", En, 4'b0100);
        chk("t1_strobe_done", done_a, 0);
        tick();
        chk("t1_hold_en", En, 4'b0000);
        chk("t1_hold_done", done_a, 1);
        chk("t1_hold_j", J, 4'b0100);
        tick();
        chk("t1_rdq", rd_q, 1);
        chk("t1_idle_done", done_a, 0);
        chk("t1_idle_j", J, 4'b0000);

        // Round-robin alternation after a fresh reset.
        do_reset();
        req_a = 1; req_b = 1; cmd_a = 2'b00; cmd_b = 2'b00;
        sel_a = 2'd0; sel_b = 2'd3;
        #1;
        chk("t2_gnt_a", gnt_a, 1);
        chk("t2_gnt_b0", gnt_b, 0);
        tick();
        req_a = 0;
        chk("t2_setup_gnt_b", gnt_b, 0);
        tick();
        tick();
        chk("t2_done_a", done_a, 1);
        chk("t2_hold_gnt_b", gnt_b, 0);
        tick();
        chk("t2_gnt_b", gnt_b, 1);
        tick();
        req_b = 0;
        tick();
        tick();
        chk("t2_done_b", done_b, 1);
        chk("t2_done_a_off", done_a, 0);
        tick();
        req_a = 1; req_b = 1;
        #1;
        chk("t2_alt_gnt_a", gnt_a, 1);
        chk("t2_alt_gnt_b", gnt_b, 0);
        tick();
        req_a = 0; req_b = 0;
        tick();
        tick();
        tick();

        // Toggle cell 1 twice from 0.
        for (int n = 0; n < 2; n++) begin
            req_a = 1; cmd_a = 2'b11; sel_a = 2'd1;
            #1;
            chk("t3_gnt", gnt_a, 1);
            tick();
            req_a = 0;
            for (int c = 0; c < 3; c++) begin
                chk("t3_j", J, 4'b0010);
                chk("t3_k", K, 4'b0010);
                tick();
            end
            chk("t3_rdq", rd_q, (n == 0) ? 1 : 0);
            chk("t3_idle_jk", {J, K}, 0);
        end

        // Reset in the middle of a strobe.
        req_a = 1; cmd_a = 2'b10; sel_a = 2'd3;
        tick();
        req_a = 0;
        tick();
        chk("t4_strobe_en", En, 4'b1000);
        rst_n = 0;
        #1;
        chk("t4_rst_en", En, 0);
        chk("t4_rst_jk", {J, K}, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done_a, 0);
        tick();
        chk("t4_rst_q", Q[3], 0);
        rst_n = 1;
        req_a = 1; req_b = 1; cmd_a = 2'b00; cmd_b = 2'b00;
        #1;
        chk("t4_rel_gnt_a", gnt_a, 1);
        chk("t4_rel_gnt_b", gnt_b, 0);
        tick();
        req_a = 0; req_b = 0;
        tick();
        tick();
        tick();

        // Long setup/strobe instance.
        req1 = 1;
        #1;
        chk("t5_gnt", g1a, 1);
        en_cnt  = 0;
        done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            req1 = 0;
            if (en1 != 4'b0000) en_cnt++;
            if (d1a) begin
                done_at = c;
                break;
            end
        end
        chk("t5_en_width", en_cnt, 2);
        chk("t5_done_lat", done_at, 6);

`ifdef JK_BANK_VERIFY_EN
        // Latch refuses to set cell 0: err goes high and stays.
        do_reset();
        force0 = 1;
        chk("t6_err_rst", err, 0);
        req_a = 1; cmd_a = 2'b10; sel_a = 2'd0;
        tick();
        req_a = 0;
        tick();
        tick();
        chk("t6_err_hold", err, 0);
        tick();
        chk("t6_err_set", err, 1);
        tick();
        tick();
        chk("t6_err_sticky", err, 1);
        rst_n = 0;
        #1;
        chk("t6_err_clr", err, 0);
        tick();
        rst_n = 1;
        force0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
